// File: rtl/gbt_link_pkg.sv
// Shared GBT link definitions: frame layout, word indices and the receive FSM encoding.
// Used by both the downlink decoder and the uplink framer.
package gbt_link_pkg;

   localparam logic [11:0] FRAME_END  = 12'hABC;
   localparam int          FRAME_LEN  = 7;
   localparam int          PAYLOAD_W  = 12;
   localparam int          NUM_FIELDS = FRAME_LEN - 1;

   // Position of each payload word inside a frame (end marker is the last word)
   localparam int W_BEGIN    = 0;
   localparam int W_ADDR_MID = 1;
   localparam int W_ADDR_LO  = 2;
   localparam int W_DATA_HI  = 3;
   localparam int W_DATA_MID = 4;
   localparam int W_DATA_LO  = 5;

   // W0..W5 are encoded as word index + 1 so field capture can decode them directly
   typedef enum logic [2:0] {
      ST_HUNT = 3'd0,
      ST_W0   = 3'd1,
      ST_W1   = 3'd2,
      ST_W2   = 3'd3,
      ST_W3   = 3'd4,
      ST_W4   = 3'd5,
      ST_W5   = 3'd6,
      ST_CHK  = 3'd7
   } rx_state_t;

   function automatic logic is_frame_end(input logic [PAYLOAD_W-1:0] p);
      return p == FRAME_END;
   endfunction

endpackage

// File: rtl/link_gbt_rx_decoder_if.sv
// E-link word input and decoded register-write request output of the GBT downlink decoder.
interface link_gbt_rx_decoder_if;

   logic [15:0] gbt_rx_data_i;
   logic        req_en_o;
   logic [31:0] req_data_o;
   logic [31:0] req_addr_o;

   // master: deserializer feeding words in and consuming requests
   modport master (
      output gbt_rx_data_i,
      input  req_en_o,
      input  req_data_o,
      input  req_addr_o
   );

   modport slave (
      input  gbt_rx_data_i,
      output req_en_o,
      output req_data_o,
      output req_addr_o
   );

endinterface

// File: rtl/link_gbt_rx_decoder.sv
// GBT downlink request parser: locks on the frame end marker, captures the six payload words
// of each 7-word frame and issues a one-cycle write request for every well-formed write frame.
module link_gbt_rx_decoder
   import gbt_link_pkg::*;
(
   input  logic               ttc_clk_40_i,
   input  logic               reset_i,
   link_gbt_rx_decoder_if.slave bus
);

   logic [PAYLOAD_W-1:0] payload;
   logic                 ttc_unused;
   logic                 end_seen;

   assign payload    = bus.gbt_rx_data_i[PAYLOAD_W-1:0];
   assign ttc_unused = ^bus.gbt_rx_data_i[15:12];
   assign end_seen   = is_frame_end(payload);

   rx_state_t state_reg, state_next;

   logic [PAYLOAD_W-1:0] field_q [NUM_FIELDS];

   logic        req_en_reg,   req_en_next;
   logic [31:0] req_data_reg, req_data_next;
   logic [31:0] req_addr_reg, req_addr_next;

   // One capture register per frame word, loaded while the FSM sits in that word's state
   genvar gi;
   generate
      for (gi = 0; gi < NUM_FIELDS; gi++) begin : g_field
         logic [PAYLOAD_W-1:0] field_reg;

         always_ff @(posedge ttc_clk_40_i) begin
            if (reset_i) begin
               field_reg <= '0;
            end else if (state_reg == rx_state_t'(gi + 1)) begin
               field_reg <= payload;
            end
         end

         assign field_q[gi] = field_reg;
      end
   endgenerate

   logic        wr_valid;
   logic        wr_en;
   logic        format_ok;
   logic [31:0] frame_addr;
   logic [31:0] frame_data;

   assign wr_valid   = field_q[W_BEGIN][11];
   assign wr_en      = field_q[W_BEGIN][10];
   assign format_ok  = (field_q[W_BEGIN][9:8] == 2'b00) && (field_q[W_DATA_HI][11:8] == 4'h0);
   assign frame_addr = {field_q[W_BEGIN][7:0],   field_q[W_ADDR_MID], field_q[W_ADDR_LO]};
   assign frame_data = {field_q[W_DATA_HI][7:0], field_q[W_DATA_MID], field_q[W_DATA_LO]};

   always_ff @(posedge ttc_clk_40_i) begin
      if (reset_i) begin
         state_reg <= ST_HUNT;
      end else begin
         state_reg <= state_next;
      end
   end

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         ST_HUNT: state_next = end_seen ? ST_W0 : ST_HUNT;
         ST_W0:   state_next = ST_W1;
         ST_W1:   state_next = ST_W2;
         ST_W2:   state_next = ST_W3;
         ST_W3:   state_next = ST_W4;
         ST_W4:   state_next = ST_W5;
         ST_W5:   state_next = ST_CHK;
         ST_CHK:  state_next = end_seen ? ST_W0 : ST_HUNT;
         default: state_next = ST_HUNT;
      endcase
   end

   // Rejected frames leave the request outputs untouched; only an accepted one reloads them
   always_comb begin
      req_en_next   = 1'b0;
      req_data_next = req_data_reg;
      req_addr_next = req_addr_reg;
      if ((state_reg == ST_CHK) && end_seen && format_ok && wr_valid && wr_en) begin
         req_en_next   = 1'b1;
         req_data_next = frame_data;
         req_addr_next = frame_addr;
      end
   end

   always_ff @(posedge ttc_clk_40_i) begin
      if (reset_i) begin
         req_en_reg   <= 1'b0;
         req_data_reg <= '0;
         req_addr_reg <= '0;
      end else begin
         req_en_reg   <= req_en_next;
         req_data_reg <= req_data_next;
         req_addr_reg <= req_addr_next;
      end
   end

   assign bus.req_en_o   = req_en_reg;
   assign bus.req_data_o = req_data_reg;
   assign bus.req_addr_o = req_addr_reg;

endmodule

// File: tb/tb_link_gbt_rx_decoder.sv
// Scoreboard bench for the GBT downlink request decoder: frames are driven word by word,
// expected requests are queued at the end marker and matched against each strobe.
module tb_link_gbt_rx_decoder;
   import gbt_link_pkg::*;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   link_gbt_rx_decoder_if bus();

   link_gbt_rx_decoder dut (
      .ttc_clk_40_i (clk),
      .reset_i      (rst),
      .bus          (bus)
   );

   typedef struct {
      logic [31:0] addr;
      logic [31:0] data;
      int          cyc;
   } exp_t;

   exp_t        sb [$];
   int          errors = 0;
   int          checks = 0;
   int          cyc    = 0;
   int          frame_no = 0;
   logic [31:0] hold_addr = '0;
   logic [31:0] hold_data = '0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   exp_t mon_e;
   always @(negedge clk) begin
      if (!rst) begin
         if (bus.req_en_o) begin
            if (sb.size() == 0) begin
               check_val("unexpected_strobe", 32'd1, 32'd0);
            end else begin
               mon_e = sb.pop_front();
               check_val("strobe_cycle", cyc, mon_e.cyc);
               check_val("req_data", bus.req_data_o, mon_e.data);
               check_val("req_addr", bus.req_addr_o, mon_e.addr);
               $display("strobe  cyc=%0d addr=%h data=%h", cyc, bus.req_addr_o, bus.req_data_o);
            end
         end else if (sb.size() != 0 && sb[0].cyc < cyc) begin
            check_val("missed_strobe", 32'd0, 32'd1);
            void'(sb.pop_front());
         end
      end
   end

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         bus.gbt_rx_data_i = 16'h0000;
      end
   endtask

   task automatic send_frame(input logic [31:0] addr, input logic [31:0] data,
                             input logic v, input logic e, input logic [1:0] f0,
                             input logic [3:0] f3, input logic [11:0] endw,
                             input logic [3:0] ttc, input logic exp_strobe, input int abort_at);
      logic [11:0] w [FRAME_LEN];
      w[0] = {v, e, f0, addr[31:24]};
      w[1] = addr[23:12];
      w[2] = addr[11:0];
      w[3] = {f3, data[31:24]};
      w[4] = data[23:12];
      w[5] = data[11:0];
      w[6] = endw;
      frame_no++;
      $display("frame %0d addr=%h data=%h v=%0b e=%0b f0=%0d f3=%h end=%h ttc=%h expect=%0b abort=%0d",
               frame_no, addr, data, v, e, f0, f3, endw, ttc, exp_strobe, abort_at);
      for (int i = 0; i < FRAME_LEN; i++) begin
         @(negedge clk);
         if (i == 0) begin
            check_val("hold_data", bus.req_data_o, hold_data);
            check_val("hold_addr", bus.req_addr_o, hold_addr);
         end
         bus.gbt_rx_data_i = {ttc, w[i]};
         if (i == abort_at) begin
            rst = 1'b1;
            @(negedge clk);
            rst = 1'b0;
            hold_addr = '0;
            hold_data = '0;
            check_val("abort_req_en", {31'd0, bus.req_en_o}, 32'd0);
            check_val("abort_data", bus.req_data_o, 32'd0);
            check_val("abort_addr", bus.req_addr_o, 32'd0);
            bus.gbt_rx_data_i = 16'h0000;
            return;
         end
         if (i == FRAME_LEN - 1 && exp_strobe) begin
            sb.push_back('{addr: addr, data: data, cyc: cyc + 1});
            hold_addr = addr;
            hold_data = data;
         end
      end
   endtask

   localparam logic [31:0] A0 = 32'h4000_0000;
   localparam logic [31:0] D0 = 32'h1234_5678;

   initial begin
      bus.gbt_rx_data_i = 16'h0000;
      rst = 1'b1;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      check_val("rst_req_en", {31'd0, bus.req_en_o}, 32'd0);
      check_val("rst_data", bus.req_data_o, 32'd0);
      check_val("rst_addr", bus.req_addr_o, 32'd0);
      idle(2);

      // first frame only locks, then back-to-back frames strobe every 7 clocks
      send_frame(A0, D0, 1, 1, 2'b00, 4'h0, FRAME_END, 4'hF, 0, -1);
      send_frame(A0, D0, 1, 1, 2'b00, 4'h0, FRAME_END, 4'hF, 1, -1);
      send_frame(A0, D0, 1, 1, 2'b00, 4'h0, FRAME_END, 4'hF, 1, -1);
      send_frame(A0, D0, 1, 1, 2'b00, 4'h0, FRAME_END, 4'hF, 1, -1);
      // write enable low: rejected, lock kept
      send_frame(32'h4000_0010, 32'hDEAD_BEEF, 1, 0, 2'b00, 4'h0, FRAME_END, 4'hF, 0, -1);
      send_frame(32'h4000_0004, 32'hCAFE_0001, 1, 1, 2'b00, 4'h0, FRAME_END, 4'hF, 1, -1);
      // corrupt end marker: lost lock, next frame relocks only
      send_frame(A0, 32'h1111_1111, 1, 1, 2'b00, 4'h0, 12'hABD, 4'hF, 0, -1);
      send_frame(A0, D0, 1, 1, 2'b00, 4'h0, FRAME_END, 4'hF, 0, -1);
      send_frame(32'h4000_0008, 32'h8765_4321, 1, 1, 2'b00, 4'h0, FRAME_END, 4'hF, 1, -1);
      // bad format nibble in w3: rejected, lock kept
      send_frame(32'h4000_000C, 32'h5555_5555, 1, 1, 2'b00, 4'h1, FRAME_END, 4'hF, 0, -1);
      send_frame(A0, D0, 1, 1, 2'b00, 4'h0, FRAME_END, 4'hF, 1, -1);
      send_frame(32'h4000_0014, 32'h0BAD_0BAD, 0, 1, 2'b00, 4'h0, FRAME_END, 4'hF, 0, -1);
      send_frame(32'h4000_0018, 32'h0BAD_0BAD, 1, 1, 2'b01, 4'h0, FRAME_END, 4'hF, 0, -1);
      send_frame(32'hFF00_0FFF, 32'h00FF_F000, 1, 1, 2'b00, 4'h0, FRAME_END, 4'h0, 1, -1);
      // reset mid-frame at w3: discard, relock like power-up
      send_frame(A0, 32'h7777_7777, 1, 1, 2'b00, 4'h0, FRAME_END, 4'hF, 0, 3);
      idle(3);
      send_frame(A0, D0, 1, 1, 2'b00, 4'h0, FRAME_END, 4'hF, 0, -1);
      send_frame(A0, D0, 1, 1, 2'b00, 4'h0, FRAME_END, 4'hF, 1, -1);
      for (int k = 0; k < 4; k++) begin
         send_frame($urandom, $urandom, 1, 1, 2'b00, 4'h0, FRAME_END,
                    4'($urandom_range(0, 15)), 1, -1);
      end

      idle(4);
      check_val("sb_drained", sb.size(), 32'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
